// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// one bit per clock, results held in the architectural HI/LO registers.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_1,
    input  logic [WIDTH-1:0] src_2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;

    // op[0] set means unsigned; op[1] set means divide.
    logic             w_signed;
    logic             w_src1_neg;
    logic             w_src2_neg;
    logic [WIDTH-1:0] w_src1_abs;
    logic [WIDTH-1:0] w_src2_abs;

    assign w_signed   = ~op[0];
    assign w_src1_neg = w_signed & src_1[WIDTH-1];
    assign w_src2_neg = w_signed & src_2[WIDTH-1];
    assign w_src1_abs = w_src1_neg ? -src_1 : src_1;
    assign w_src2_abs = w_src2_neg ? -src_2 : src_2;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting out / quotient bits in}.
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // Divide by zero leaves the magnitude of the dividend as remainder, so restoring its
    // sign reproduces src_1 exactly; only the quotient needs forcing.
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_div0  ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_count  <= '0;
            r_b      <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start && !flush) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_src1_neg ^ w_src2_neg;
                        r_neg_r  <= w_src1_neg;
                        r_div0   <= op[1] && (src_2 == '0);
                        r_b      <= w_src2_abs;
                        r_acc    <= {{WIDTH{1'b0}}, w_src1_abs};
                        r_count  <= '0;
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= r_is_div ? w_div_next : w_mul_next;
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(WIDTH - 1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: arithmetic results, latency, flush, ignored inputs, reset.
module tb_mdu_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_1;
    logic [31:0] src_2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_1 (src_1),
        .src_2 (src_2),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op at the next edge and returns edges counted from the start edge
    // (start edge = 1) until done is seen, plus the number of cycles busy was high.
    task automatic issue_and_wait(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output int busy_cyc);
        @(negedge clk);
        op = o; src_1 = a; src_2 = b; start = 1'b1;
        lat = 0; busy_cyc = 0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; src_1 = '0; src_2 = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #2;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Latency and busy-duration checks for the first MULT, result checks for every vector.
    task automatic test_arith(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input bit check_timing);
        int lat, busy_cyc;
        issue_and_wait(o, a, b, lat, busy_cyc);
        n_tests++; if (hi !== exp_hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi); end
        n_tests++; if (lo !== exp_lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo); end
        n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL %s_latency: got %0d expected 34", name, lat); end
        if (check_timing) begin
            n_tests++; if (busy_cyc !== 33) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected 33", name, busy_cyc); end
            @(negedge clk);
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b expected 0", name, done); end
        end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        n_tests++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi: got %h expected 00001234", hi); end
        lo_we = 1'b1; wdata = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        n_tests++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo: got %h expected 00005678", lo); end
        n_tests++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", hi); end
    endtask

    task automatic test_flush();
        bit saw_done;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        op = OP_MULT; src_1 = 32'd6; src_2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
        n_tests++; if (hi !== 32'h0000_AAAA) begin n_fail++; $display("FAIL flush_hi: got %h expected 0000aaaa", hi); end
        n_tests++; if (lo !== 32'h0000_AAAA) begin n_fail++; $display("FAIL flush_lo: got %h expected 0000aaaa", lo); end
        // flush together with start in IDLE drops the start.
        op = OP_MULTU; src_1 = 32'd2; src_2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_dropped: got busy %b expected 0", busy); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        bit saw_done;
        @(negedge clk);
        // MTHI on the start edge lands, later overwritten by the result.
        op = OP_MULTU; src_1 = 32'd2; src_2 = 32'd3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hDEAD_0001;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        lat = 1;
        n_tests++; if (hi !== 32'hDEAD_0001) begin n_fail++; $display("FAIL mthi_with_start: got %h expected dead0001", hi); end
        repeat (4) @(negedge clk);
        lat += 4;
        // Second start plus MTHI/MTLO while busy: all must be ignored.
        op = OP_DIVU; src_1 = 32'd100; src_2 = 32'd0; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF_BEEF;
        @(negedge clk);
        lat++;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_tests++; if (hi !== 32'hDEAD_0001) begin n_fail++; $display("FAIL busy_mthi_ignored: got %h expected dead0001", hi); end
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL busy_start_hi: got %h expected 00000000", hi); end
        n_tests++; if (lo !== 32'h6) begin n_fail++; $display("FAIL busy_start_lo: got %h expected 00000006", lo); end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued: got %b expected 0", saw_done); end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        op = OP_MULT; src_1 = 32'hFFFF_FFFD; src_2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midreset_hi: got %h expected 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL midreset_lo: got %h expected 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        test_arith("post_reset_mult", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
    endtask

    initial begin
        test_reset();
        test_arith("mult_neg3x5",  OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
        test_arith("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        test_arith("mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        test_arith("div_neg7by2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        test_arith("divu_7by2",    OP_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 1'b0);
        test_arith("div_min_by_m1",OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        test_arith("div_7by_neg2", OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        test_arith("divu_7by0",    OP_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
        test_arith("div_neg5by0",  OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        test_mthi_mtlo();
        test_flush();
        test_start_while_busy();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
